hilo_muldiv_sequencer: RTL
==========================

// Module: hilo_muldiv_sequencer
// PURPOSE
//  Multi-cycle sequencer for the HI/LO multiply/divide resource in EX.
//  Decodes ALU control codes 8,9,15-18 (mult/multu/div/divu/madd/msub) and 21-24
//  (mfhi/mthi/mflo/mtlo). Runs an iterative radix-2 divider and a fixed-latency
//  multiplier, owns the HI/LO registers, and stalls the pipeline while busy.
// PARAMETERS
//  MUL_LATENCY  4   cycles from accept to HI/LO write for mult/multu/madd/msub (>=1)
//  DIV_ITERS    32  restoring-divide iterations (fixed at 32 for 32-bit operands)
// PORTS
//  Clk       in   1   single clock, all state updates on rising edge
//  Reset     in   1   synchronous, active-high reset
//  ReqValid  in   1   EX-stage instruction is valid this cycle
//  ALUCtl    in   5   ALU control code of the EX-stage instruction
//  A         in   32  rs operand (dividend / multiplicand / mthi/mtlo data)
//  B         in   32  rt operand (divisor / multiplier)
//  Busy      out  1   multiply or divide in flight
//  Stall     out  1   freeze PC/IF/ID/EX; hold the request
//  ReadData  out  32  HI (code 21) or LO (code 23); 0 for any other code
//  HiOut     out  32  current HI register
//  LoOut     out  32  current LO register
//  Done      out  1   one-cycle pulse: first cycle new mul/div result is visible
// BEHAVIOUR
//  Reset: state IDLE, HI=LO=0, counter=0, Busy=Stall=Done=0. Mid-op reset aborts; no HI/LO write.
//  HiLoOp = ReqValid & ALUCtl in {8,9,15,16,17,18,21,22,23,24}. Other codes: ignored, no stall.
//  Stall = HiLoOp & Busy (combinational). Accept = HiLoOp & !Busy.
//  States: IDLE, MUL, DIV, FIX.
//   IDLE: accept mul-class -> MUL, count=MUL_LATENCY-1; accept div-class -> DIV, count=31.
//         Operands A,B and the op code are latched on the accept edge.
//         mthi/mtlo: write HI/LO on the accept edge, stay IDLE, Busy stays 0.
//         mfhi/mflo: ReadData = HI/LO combinationally, no state change.
//   MUL: count down; at count==0 write HI/LO, -> IDLE. Write lands MUL_LATENCY edges after accept.
//   DIV: one restoring step per cycle on magnitudes; at count==0 -> FIX.
//   FIX: apply signs, write HI/LO, -> IDLE. Write lands 33 edges after accept.
//  Busy = (state != IDLE). Done = 1 in the IDLE cycle right after a MUL/DIV/FIX write.
//  A HiLoOp presented in the Done cycle is accepted that cycle (back-to-back, no bubble).
//  Arithmetic (all products 64-bit, mod 2^64):
//   mult  {HI,LO} = signed(A)*signed(B);     multu {HI,LO} = A*B unsigned
//   madd  {HI,LO} += signed(A)*signed(B);    msub  {HI,LO} -= signed(A)*signed(B)
//   madd/msub use HI/LO as latched at accept (no intervening writer possible).
//   div   LO = quotient truncated toward zero, HI = remainder with dividend's sign
//   divu  LO = A/B, HI = A%B unsigned
//   0x80000000 / -1 (div): LO=0x80000000, HI=0 (wrap, no trap)
//   B==0: LO=0xFFFFFFFF, HI=A (div and divu; signed div applies no sign fix)
//  ReqValid deasserted while Busy: the in-flight op still completes; no abort except Reset.
// CONFIGURATION
//  DIV_ZERO_FAST_EN defined: div/divu with B==0 skip DIV/FIX; HI/LO written on the
//   accept edge (HI=A, LO=0xFFFFFFFF); Busy stays 0; Done pulses next cycle.
//  Not defined: B==0 runs the full 33-cycle path with the same HI/LO result.
// TESTING
//  Reset, then mtlo A=0x12345678, mflo -> ReadData=0x12345678 same cycle, Stall=0, Busy=0.
//  mult A=-3 B=7 -> Busy high 4 cycles, HI=0xFFFFFFFF LO=0xFFFFFFEB, Done one pulse.
//  div A=-7 B=2, then mfhi held -> Stall=1 for 33 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//  divu A=0x80000000 B=0 -> HI=0x80000000 LO=0xFFFFFFFF; 33 cycles / 0 cycles with DIV_ZERO_FAST_EN.
//  HI=0 LO=10 via mthi/mtlo, madd A=2 B=3 in Done cycle of prior op -> LO=16, no bubble.
//  Reset asserted at cycle 10 of a div -> next cycle Busy=0, HI=LO=0, no Done pulse.

Source files
------------

// File: rtl/hilo_muldiv_sequencer.sv
// HI/LO multiply/divide sequencer: fixed-latency multiplier, radix-2 restoring divider, HI/LO owner.
// Optional macro DIV_ZERO_FAST_EN: divide by zero completes on the accept edge instead of iterating.
module hilo_muldiv_sequencer #(
  parameter int MUL_LATENCY = 4,
  parameter int DIV_ITERS   = 32
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        ReqValid,
  input  logic [4:0]  ALUCtl,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic        Stall,
  output logic [31:0] ReadData,
  output logic [31:0] HiOut,
  output logic [31:0] LoOut,
  output logic        Done
);

  localparam logic [4:0] OP_MULT  = 5'd8;
  localparam logic [4:0] OP_MULTU = 5'd9;
  localparam logic [4:0] OP_DIV   = 5'd15;
  localparam logic [4:0] OP_DIVU  = 5'd16;
  localparam logic [4:0] OP_MADD  = 5'd17;
  localparam logic [4:0] OP_MSUB  = 5'd18;
  localparam logic [4:0] OP_MFHI  = 5'd21;
  localparam logic [4:0] OP_MTHI  = 5'd22;
  localparam logic [4:0] OP_MFLO  = 5'd23;
  localparam logic [4:0] OP_MTLO  = 5'd24;

  localparam logic [7:0] MUL_INIT = 8'(MUL_LATENCY - 1);
  localparam logic [7:0] DIV_INIT = 8'(DIV_ITERS - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t      state, state_n;
  logic [7:0]  cnt;
  logic [31:0] hi, lo, hi_n, lo_n;
  logic [31:0] a_q, b_q, quo, rem, dvs;
  logic [4:0]  op_q;
  logic        done_q, fin;

  logic mul_cls, div_cls, mv_cls, hilo_op, accept;

  assign mul_cls = ALUCtl inside {OP_MULT, OP_MULTU, OP_MADD, OP_MSUB};
  assign div_cls = ALUCtl inside {OP_DIV, OP_DIVU};
  assign mv_cls  = ALUCtl inside {OP_MFHI, OP_MTHI, OP_MFLO, OP_MTLO};
  assign hilo_op = ReqValid & (mul_cls | div_cls | mv_cls);
  assign Busy    = (state != IDLE);
  assign Stall   = hilo_op & Busy;
  assign accept  = hilo_op & ~Busy;
  assign HiOut   = hi;
  assign LoOut   = lo;
  assign Done    = done_q;

  always_comb begin
    ReadData = 32'd0;
    if (ALUCtl == OP_MFHI) ReadData = hi;
    else if (ALUCtl == OP_MFLO) ReadData = lo;
  end

  // Signed divide works on magnitudes; signs are restored in FIX.
  logic        in_signed;
  logic [31:0] a_mag, b_mag;
  assign in_signed = (ALUCtl == OP_DIV);
  assign a_mag = (in_signed & A[31]) ? -A : A;
  assign b_mag = (in_signed & B[31]) ? -B : B;

  logic [32:0] rem_sh;
  logic [33:0] diff;
  assign rem_sh = {rem, quo[31]};
  assign diff   = {1'b0, rem_sh} - {2'b00, dvs};

  logic [63:0] sa, sb, ps, pu, acc, mul_res;
  assign sa  = {{32{a_q[31]}}, a_q};
  assign sb  = {{32{b_q[31]}}, b_q};
  assign ps  = sa * sb;
  assign pu  = {32'd0, a_q} * {32'd0, b_q};
  assign acc = {hi, lo};

  always_comb begin
    case (op_q)
      OP_MULTU: mul_res = pu;
      OP_MADD:  mul_res = acc + ps;
      OP_MSUB:  mul_res = acc - ps;
      default:  mul_res = ps;
    endcase
  end

  logic        q_neg, r_neg;
  logic [31:0] div_hi, div_lo;
  always_comb begin
    q_neg = (op_q == OP_DIV) & (a_q[31] ^ b_q[31]);
    r_neg = (op_q == OP_DIV) & a_q[31];
    if (b_q == 32'd0) begin
      div_hi = a_q;
      div_lo = 32'hFFFF_FFFF;
    end else begin
      div_hi = r_neg ? -rem : rem;
      div_lo = q_neg ? -quo : quo;
    end
  end

  always_comb begin
    state_n = state;
    hi_n    = hi;
    lo_n    = lo;
    fin     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (ALUCtl == OP_MTHI) hi_n = A;
          if (ALUCtl == OP_MTLO) lo_n = A;
          if (mul_cls) state_n = MUL;
          if (div_cls) begin
`ifdef DIV_ZERO_FAST_EN
            if (B == 32'd0) begin
              hi_n = A;
              lo_n = 32'hFFFF_FFFF;
              fin  = 1'b1;
            end else begin
              state_n = DIV;
            end
`else
            state_n = DIV;
`endif
          end
        end
      end
      MUL: begin
        if (cnt == 8'd0) begin
          {hi_n, lo_n} = mul_res;
          state_n      = IDLE;
          fin          = 1'b1;
        end
      end
      DIV: begin
        if (cnt == 8'd0) state_n = FIX;
      end
      FIX: begin
        hi_n    = div_hi;
        lo_n    = div_lo;
        state_n = IDLE;
        fin     = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      hi     <= 32'd0;
      lo     <= 32'd0;
      done_q <= 1'b0;
      cnt    <= 8'd0;
      a_q    <= 32'd0;
      b_q    <= 32'd0;
      op_q   <= 5'd0;
      quo    <= 32'd0;
      rem    <= 32'd0;
      dvs    <= 32'd0;
    end else begin
      hi     <= hi_n;
      lo     <= lo_n;
      done_q <= fin;
      if (accept && (mul_cls || div_cls)) begin
        a_q  <= A;
        b_q  <= B;
        op_q <= ALUCtl;
        cnt  <= mul_cls ? MUL_INIT : DIV_INIT;
        quo  <= a_mag;
        dvs  <= b_mag;
        rem  <= 32'd0;
      end
      if (state == MUL && cnt != 8'd0) cnt <= cnt - 8'd1;
      if (state == DIV) begin
        if (!diff[33]) begin
          rem <= diff[31:0];
          quo <= {quo[30:0], 1'b1};
        end else begin
          rem <= rem_sh[31:0];
          quo <= {quo[30:0], 1'b0};
        end
        if (cnt != 8'd0) cnt <= cnt - 8'd1;
      end
    end
  end

endmodule
